// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: divides the system clock to a pixel tick and
// produces position counters, syncs, visible-window flag and line/frame strobes.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_TOTAL   = 800,
  parameter int H_SYNC    = 96,
  parameter int H_ACT_BEG = 144,
  parameter int H_ACT_END = 784,
  parameter int V_TOTAL   = 525,
  parameter int V_SYNC    = 2,
  parameter int V_ACT_BEG = 35,
  parameter int V_ACT_END = 515
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        pix_tick,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_BEG = 10'(H_ACT_BEG);
  localparam logic [9:0] H_END = 10'(H_ACT_END);
  localparam logic [9:0] V_BEG = 10'(V_ACT_BEG);
  localparam logic [9:0] V_END = 10'(V_ACT_END);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_next;
  logic             h_wrap;
  logic             v_wrap;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             bright_next;

  // Syncs and bright are derived from the upcoming position so they move with the counters.
  always_comb begin
    tick_next = (div_cnt == DIV_LAST);
    h_wrap    = (hCount >= H_LAST);
    v_wrap    = (vCount >= V_LAST);
    h_next    = h_wrap ? 10'd0 : hCount + 10'd1;
    v_next    = vCount;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vCount + 10'd1;
    end
    hsync_next  = ~(h_next < H_SYNC_END);
    vsync_next  = ~(v_next < V_SYNC_END);
    bright_next = (h_next >= H_BEG) && (h_next < H_END) &&
                  (v_next >= V_BEG) && (v_next < V_END);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_cnt  <= tick_next ? '0 : div_cnt + DIV_W'(1);
      pix_tick <= tick_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= tick_next && h_wrap;
      frame_start <= tick_next && h_wrap && v_wrap;
      if (tick_next) begin
        hCount <= h_next;
        vCount <= v_next;
        hSync  <= hsync_next;
        vSync  <= vsync_next;
        bright <= bright_next;
        if (h_wrap && v_wrap) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: an arithmetic raster model checked every cycle on three
// parameterisations, plus directed literal checks of latency, periods and corners.
module tb_vga_timing_gen;

  logic clk;
  logic rst0, rst1, rst2;

  logic        pix_tick0, hSync0, vSync0, bright0, line_start0, frame_start0;
  logic [9:0]  hCount0, vCount0;
  logic [15:0] frame_count0;
  logic        pix_tick1, hSync1, vSync1, bright1, line_start1, frame_start1;
  logic [9:0]  hCount1, vCount1;
  logic [15:0] frame_count1;
  logic        pix_tick2, hSync2, vSync2, bright2, line_start2, frame_start2;
  logic [9:0]  hCount2, vCount2;
  logic [15:0] frame_count2;

  int total = 0;
  int bad   = 0;

  longint      k0 = 0, k1 = 0, k2 = 0;
  logic [15:0] base2 = 16'h0;

  vga_timing_gen dut0 (
    .clk(clk), .reset_n(rst0), .pix_tick(pix_tick0), .hCount(hCount0), .vCount(vCount0),
    .hSync(hSync0), .vSync(vSync0), .bright(bright0), .line_start(line_start0),
    .frame_start(frame_start0), .frame_count(frame_count0)
  );

  vga_timing_gen #(.CLK_DIV(1), .V_TOTAL(6), .V_SYNC(2), .V_ACT_BEG(1), .V_ACT_END(5)) dut1 (
    .clk(clk), .reset_n(rst1), .pix_tick(pix_tick1), .hCount(hCount1), .vCount(vCount1),
    .hSync(hSync1), .vSync(vSync1), .bright(bright1), .line_start(line_start1),
    .frame_start(frame_start1), .frame_count(frame_count1)
  );

  vga_timing_gen #(.CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_ACT_BEG(5), .H_ACT_END(17),
                   .V_TOTAL(12), .V_SYNC(2), .V_ACT_BEG(3), .V_ACT_END(10)) dut2 (
    .clk(clk), .reset_n(rst2), .pix_tick(pix_tick2), .hCount(hCount2), .vCount(vCount2),
    .hSync(hSync2), .vSync(vSync2), .bright(bright2), .line_start(line_start2),
    .frame_start(frame_start2), .frame_count(frame_count2)
  );

  wire [41:0] act0 = {pix_tick0, line_start0, frame_start0, hSync0, vSync0, bright0,
                      hCount0, vCount0, frame_count0};
  wire [41:0] act1 = {pix_tick1, line_start1, frame_start1, hSync1, vSync1, bright1,
                      hCount1, vCount1, frame_count1};
  wire [41:0] act2 = {pix_tick2, line_start2, frame_start2, hSync2, vSync2, bright2,
                      hCount2, vCount2, frame_count2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = clock edges seen with reset released; everything else follows from pixel index k/d.
  function automatic logic [41:0] expect_out(longint k, int d, int ht, int hs, int hab, int hae,
                                             int vt, int vs, int vab, int vae, logic [15:0] base);
    longint n, p;
    int h, v;
    logic tick, ls, fs, hsy, vsy, br;
    logic [15:0] fc;
    tick = (k > 0) && (k % d == 0);
    n    = k / d;
    p    = n % (ht * vt);
    h    = int'(p % ht);
    v    = int'(p / ht);
    fc   = base + 16'(n / (ht * vt));
    ls   = tick && (h == 0);
    fs   = ls && (v == 0);
    hsy  = !(h < hs);
    vsy  = !(v < vs);
    br   = (h >= hab) && (h < hae) && (v >= vab) && (v < vae);
    return {tick, ls, fs, hsy, vsy, br, 10'(h), 10'(v), fc};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst0) k0 = 0;
  always @(negedge rst1) k1 = 0;
  always @(negedge rst2) begin
    k2 = 0;
    base2 = 16'h0;
  end

  always @(posedge clk) begin
    k0 = rst0 ? k0 + 1 : 0;
    k1 = rst1 ? k1 + 1 : 0;
    k2 = rst2 ? k2 + 1 : 0;
    #1;
    check_output("dut0 model", 64'(act0),
                 64'(expect_out(k0, 4, 800, 96, 144, 784, 525, 2, 35, 515, 16'h0)));
    check_output("dut1 model", 64'(act1),
                 64'(expect_out(k1, 1, 800, 96, 144, 784, 6, 2, 1, 5, 16'h0)));
    check_output("dut2 model", 64'(act2),
                 64'(expect_out(k2, 2, 20, 3, 5, 17, 12, 2, 3, 10, base2)));
  end

  task automatic wait_pos2(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (hCount2 == 10'(h) && vCount2 == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_stimulus_div4();
    int lat, clks, low;
    bit ok;
    @(negedge clk) rst0 = 1'b1;
    repeat (1000) @(posedge clk);
    #3 rst0 = 1'b0;
    #1 check_output("async reset clears", 64'(act0), 64'h0);
    @(negedge clk) rst0 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (pix_tick0) begin
        lat = i;
        break;
      end
    end
    check_output("first tick latency", 64'(lat), 64'd4);
    check_output("first tick hCount", 64'(hCount0), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (line_start0) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("line_start seen", 64'(ok), 64'd1);
    check_output("wrap hCount", 64'(hCount0), 64'd0);
    check_output("wrap vCount", 64'(vCount0), 64'd1);
    low  = 1;
    clks = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      clks++;
      if (line_start0) break;
      if (pix_tick0 && !hSync0) low++;
    end
    check_output("line period clks", 64'(clks), 64'd3200);
    check_output("hSync low ticks", 64'(low), 64'd96);
    check_output("second wrap vCount", 64'(vCount0), 64'd2);
  endtask

  task automatic apply_stimulus_div1();
    int ones, clks;
    bit ok;
    @(negedge clk) rst1 = 1'b1;
    ones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (pix_tick1) ones++;
    end
    check_output("div1 pix_tick steady", 64'(ones), 64'd20);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (line_start1) begin
        ok = 1'b1;
        break;
      end
    end
    clks = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      clks++;
      if (line_start1) break;
    end
    check_output("div1 line seen", 64'(ok), 64'd1);
    check_output("div1 line clks", 64'(clks), 64'd800);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (frame_start1) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("div1 first frame", 64'({ok, frame_count1}), 64'({1'b1, 16'd1}));
    clks = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      clks++;
      if (frame_start1) break;
    end
    check_output("div1 frame clks", 64'(clks), 64'd4800);
    check_output("div1 frame_count 2", 64'(frame_count1), 64'd2);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (vCount1 == 10'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("div1 reached line 3", 64'(ok), 64'd1);
    repeat (100) @(posedge clk);
    #3 rst1 = 1'b0;
    #1 check_output("div1 mid-frame reset", 64'({pix_tick1, hCount1, vCount1}), 64'h0);
    @(negedge clk) rst1 = 1'b1;
    @(posedge clk); #1;
    check_output("div1 restart", 64'({pix_tick1, hCount1, vCount1}), 64'({1'b1, 10'd1, 10'd0}));
  endtask

  task automatic apply_stimulus_small();
    int clks, low;
    bit ok;
    @(negedge clk) rst2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (frame_start2) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("small first frame", 64'({ok, frame_count2}), 64'({1'b1, 16'd1}));
    low  = 1;
    clks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      clks++;
      if (frame_start2) break;
      if (pix_tick2 && !vSync2) low++;
    end
    check_output("small frame clks", 64'(clks), 64'd480);
    check_output("small vSync low ticks", 64'(low), 64'd40);
    check_output("small frame_count 2", 64'(frame_count2), 64'd2);
    wait_pos2(4, 3, ok);
    check_output("corner (4,3)", 64'({ok, bright2}), 64'({1'b1, 1'b0}));
    wait_pos2(5, 3, ok);
    check_output("corner (5,3)", 64'({ok, bright2}), 64'({1'b1, 1'b1}));
    wait_pos2(16, 9, ok);
    check_output("corner (16,9)", 64'({ok, bright2}), 64'({1'b1, 1'b1}));
    wait_pos2(17, 9, ok);
    check_output("corner (17,9)", 64'({ok, bright2}), 64'({1'b1, 1'b0}));
    wait_pos2(5, 10, ok);
    check_output("corner (5,10)", 64'({ok, bright2}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    base2 = 16'hFFFF - 16'((k2 / 2) / 240);
    force dut2.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut2.frame_count;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (frame_start2) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("frame_count wrap", 64'({ok, frame_count2}), 64'({1'b1, 16'h0000}));
    check_output("frame/line coincide", 64'(line_start2), 64'd1);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset state", 64'(act0), 64'h0);
    apply_stimulus_div4();
    apply_stimulus_div1();
    apply_stimulus_small();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
